pool_scheduler: RTL and testbench

//   Sequences the hashing pool inside top: takes a loaded job and walks the shared nonce range

---
 rtl/pool_scheduler.sv | 137 +++++++++++++
 tb/tb_pool_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_scheduler.sv
// pool_scheduler: walks a job's nonce range one pool round at a time and reports the winning core.
// Define POOL_WATCHDOG_EN to enable the WAIT-state watchdog and the sticky fault_out flag.
module pool_scheduler #(
    parameter int unsigned POOL_SIZE       = 2,
    parameter int unsigned POOL_SIZE_LOG2  = 1,
    parameter int unsigned WATCHDOG_CYCLES = 4096
) (
    input  logic                        clk_in,
    input  logic                        reset_n_in,
    input  logic                        job_load_in,
    input  logic [31:0]                 nonce_start_in,
    input  logic                        halt_in,
    input  logic                        pool_done_in,
    input  logic [POOL_SIZE-1:0]        pool_success_in,
    output logic                        pool_start_out,
    output logic                        pool_abort_out,
    output logic [31-POOL_SIZE_LOG2:0]  nonce_out,
    output logic [POOL_SIZE_LOG2-1:0]   winner_idx_out,
    output logic                        ready_out,
    output logic                        exhausted_out,
    output logic                        busy_out,
    output logic                        fault_out
);

    localparam int unsigned NW = 32 - POOL_SIZE_LOG2;

    typedef enum logic [2:0] {IDLE, START, WAIT, SUCCESS, EXHAUSTED} state_t;
    state_t state;

    logic [POOL_SIZE_LOG2-1:0] lowest_idx;
    logic                      in_flight;

    always_comb begin
        lowest_idx = '0;
        for (int unsigned i = POOL_SIZE; i > 0; i--) begin
            if (pool_success_in[i-1]) lowest_idx = POOL_SIZE_LOG2'(i - 1);
        end
    end

    assign in_flight = (state == START) || (state == WAIT);

`ifdef POOL_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES + 1);
    logic [WD_W-1:0] wd_count;
`endif

    // Low nonce bits select the core within a round, so they never reach the round counter.
    logic unused_ok;
`ifdef POOL_WATCHDOG_EN
    assign unused_ok = ^nonce_start_in[POOL_SIZE_LOG2-1:0];
`else
    assign unused_ok = ^{nonce_start_in[POOL_SIZE_LOG2-1:0], WATCHDOG_CYCLES};
    assign fault_out = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state          <= IDLE;
            pool_start_out <= 1'b0;
            pool_abort_out <= 1'b0;
            nonce_out      <= '0;
            winner_idx_out <= '0;
            ready_out      <= 1'b0;
            exhausted_out  <= 1'b0;
            busy_out       <= 1'b0;
`ifdef POOL_WATCHDOG_EN
            fault_out      <= 1'b0;
            wd_count       <= '0;
`endif
        end else begin
            pool_start_out <= 1'b0;
            pool_abort_out <= 1'b0;
            if (halt_in) begin
                pool_abort_out <= in_flight;
                ready_out      <= 1'b0;
                exhausted_out  <= 1'b0;
                busy_out       <= 1'b0;
                state          <= IDLE;
            end else if (job_load_in) begin
                // A running round is aborted first; START then issues the start pulse a cycle later.
                pool_abort_out <= in_flight;
                pool_start_out <= !in_flight;
                nonce_out      <= nonce_start_in[31:POOL_SIZE_LOG2];
                ready_out      <= 1'b0;
                exhausted_out  <= 1'b0;
                busy_out       <= 1'b1;
`ifdef POOL_WATCHDOG_EN
                fault_out      <= 1'b0;
`endif
                state          <= START;
            end else begin
                case (state)
                    START: begin
                        if (pool_start_out) begin
                            state <= WAIT;
`ifdef POOL_WATCHDOG_EN
                            wd_count <= '0;
`endif
                        end else begin
                            pool_start_out <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (pool_done_in) begin
                            if (|pool_success_in) begin
                                winner_idx_out <= lowest_idx;
                                ready_out      <= 1'b1;
                                busy_out       <= 1'b0;
                                state          <= SUCCESS;
                            end else if (&nonce_out) begin
                                exhausted_out  <= 1'b1;
                                busy_out       <= 1'b0;
                                state          <= EXHAUSTED;
                            end else begin
                                nonce_out      <= nonce_out + NW'(1);
                                pool_start_out <= 1'b1;
                                state          <= START;
                            end
                        end
`ifdef POOL_WATCHDOG_EN
                        else if (wd_count == WD_W'(WATCHDOG_CYCLES - 1)) begin
                            pool_abort_out <= 1'b1;
                            fault_out      <= 1'b1;
                            busy_out       <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            wd_count <= wd_count + WD_W'(1);
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pool_scheduler.sv
// Scoreboard bench for pool_scheduler: transaction-level model predicts pulses and results, monitor checks them.
module tb_pool_scheduler;

    localparam int unsigned PS = 2;
    localparam int unsigned LG = 1;
    localparam int unsigned WD = 16;
    localparam int unsigned NW = 32 - LG;

    logic          clk = 1'b0;
    logic          reset_n, job_load, halt, pool_done;
    logic [31:0]   nonce_start;
    logic [PS-1:0] pool_success;
    logic          pool_start_out, pool_abort_out, ready_out, exhausted_out, busy_out, fault_out;
    logic [NW-1:0] nonce_out;
    logic [LG-1:0] winner_idx_out;

    always #5 clk = ~clk;

    pool_scheduler #(
        .POOL_SIZE(PS),
        .POOL_SIZE_LOG2(LG),
        .WATCHDOG_CYCLES(WD)
    ) dut (
        .clk_in(clk),
        .reset_n_in(reset_n),
        .job_load_in(job_load),
        .nonce_start_in(nonce_start),
        .halt_in(halt),
        .pool_done_in(pool_done),
        .pool_success_in(pool_success),
        .pool_start_out(pool_start_out),
        .pool_abort_out(pool_abort_out),
        .nonce_out(nonce_out),
        .winner_idx_out(winner_idx_out),
        .ready_out(ready_out),
        .exhausted_out(exhausted_out),
        .busy_out(busy_out),
        .fault_out(fault_out)
    );

    typedef enum int {EV_START, EV_ABORT, EV_SUCCESS, EV_EXH} ev_kind_t;
    typedef struct {
        ev_kind_t      kind;
        int unsigned   cyc;
        logic [NW-1:0] nonce;
        int unsigned   win;
    } ev_t;

    ev_t           sb[$];
    int            checks = 0;
    int            failures = 0;
    int unsigned   cyc = 0;
    bit            busy_m = 0;
    logic [NW-1:0] nonce_m = '0;
    logic          ready_q = 1'b0;
    logic          exh_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input ev_kind_t k, input int unsigned c, input logic [NW-1:0] n,
                                 input int unsigned w);
        ev_t e;
        e.kind = k; e.cyc = c; e.nonce = n; e.win = w;
        sb.push_back(e);
    endfunction

    // A newer command supersedes any response still planned for later cycles.
    function automatic void purge();
        while (sb.size() > 0 && sb[sb.size()-1].cyc > cyc) void'(sb.pop_back());
    endfunction

    function automatic int unsigned lowest(input logic [PS-1:0] v);
        for (int i = 0; i < PS; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic expect_ev(input ev_kind_t k);
        ev_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got %s at cycle %0d expected none", k.name(), cyc);
        end else begin
            e = sb.pop_front();
            check("event_kind", k, e.kind);
            check("event_cycle", cyc, e.cyc);
            if (k != EV_ABORT) check("event_nonce", nonce_out, e.nonce);
            if (k == EV_SUCCESS) check("event_winner", winner_idx_out, e.win);
        end
    endtask

    always @(negedge clk) begin
        check("start_abort_exclusive", pool_start_out & pool_abort_out, 0);
        if (pool_start_out) expect_ev(EV_START);
        if (pool_abort_out) expect_ev(EV_ABORT);
        if (ready_out && !ready_q) expect_ev(EV_SUCCESS);
        if (exhausted_out && !exh_q) expect_ev(EV_EXH);
        ready_q = ready_out;
        exh_q   = exhausted_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_job(input logic [31:0] s);
        purge();
        nonce_start = s;
        job_load    = 1'b1;
        if (busy_m) begin
            push(EV_ABORT, cyc + 1, '0, 0);
            push(EV_START, cyc + 2, s[31:LG], 0);
        end else begin
            push(EV_START, cyc + 1, s[31:LG], 0);
        end
        busy_m  = 1;
        nonce_m = s[31:LG];
        tick();
        job_load    = 1'b0;
        nonce_start = $urandom;
    endtask

    task automatic wait_start();
        int unsigned n = 0;
        while (!pool_start_out && n < 10) begin
            tick();
            n++;
        end
        if (!pool_start_out) begin
            checks++;
            failures++;
            $display("FAIL start_timeout: got no start pulse expected one within 10 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic do_round(input logic [PS-1:0] succ);
        wait_start();
        repeat ($urandom_range(1, 4)) begin
            tick();
            pool_success = PS'($urandom);
        end
        pool_done    = 1'b1;
        pool_success = succ;
        if (succ != 0) begin
            push(EV_SUCCESS, cyc + 1, nonce_m, lowest(succ));
            busy_m = 0;
        end else if (nonce_m == {NW{1'b1}}) begin
            push(EV_EXH, cyc + 1, nonce_m, 0);
            busy_m = 0;
        end else begin
            nonce_m = nonce_m + 1;
            push(EV_START, cyc + 1, nonce_m, 0);
        end
        tick();
        pool_done    = 1'b0;
        pool_success = '0;
    endtask

    task automatic do_halt(input bit with_job);
        purge();
        halt = 1'b1;
        if (with_job) begin
            job_load    = 1'b1;
            nonce_start = $urandom;
        end
        if (busy_m) push(EV_ABORT, cyc + 1, '0, 0);
        busy_m = 0;
        tick();
        halt     = 1'b0;
        job_load = 1'b0;
        check("halt_busy", busy_out, 0);
        check("halt_ready", ready_out, 0);
        check("halt_exhausted", exhausted_out, 0);
    endtask

    task automatic idle_done();
        pool_done    = 1'b1;
        pool_success = PS'($urandom);
        tick();
        pool_done    = 1'b0;
        pool_success = '0;
    endtask

    task automatic do_reset();
        purge();
        reset_n = 1'b0;
        busy_m  = 0;
        tick();
        check("rst_busy", busy_out, 0);
        check("rst_ready", ready_out, 0);
        check("rst_nonce", nonce_out, 0);
        check("rst_fault", fault_out, 0);
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_nonce();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 1) == 1) v[31:3] = '1;
        return v;
    endfunction

    initial begin
        int unsigned r;
        logic [PS-1:0] s;
        reset_n = 1'b0; job_load = 1'b0; halt = 1'b0; pool_done = 1'b0;
        pool_success = '0; nonce_start = '0;
        repeat (3) tick();
        check("reset_start", pool_start_out, 0);
        check("reset_abort", pool_abort_out, 0);
        check("reset_nonce", nonce_out, 0);
        check("reset_winner", winner_idx_out, 0);
        check("reset_ready", ready_out, 0);
        check("reset_exhausted", exhausted_out, 0);
        check("reset_busy", busy_out, 0);
        check("reset_fault", fault_out, 0);
        reset_n = 1'b1;
        tick();

        do_job(32'h0000_0010);
        check("t1_busy", busy_out, 1);
        do_round('0); do_round('0); do_round('0); do_round(2'b10);
        check("t1_nonce", nonce_out, 11);
        check("t1_winner", winner_idx_out, 1);
        check("t1_ready", ready_out, 1);
        check("t1_busy_low", busy_out, 0);

        do_job($urandom);
        do_round(2'b11);
        check("t2_winner", winner_idx_out, 0);

        do_job(32'hFFFF_FFFE);
        do_round('0);
        repeat (3) tick();
        check("t3_exhausted", exhausted_out, 1);
        check("t3_nonce", nonce_out, 31'h7FFF_FFFF);
        idle_done();
        check("t3_nonce_held", nonce_out, 31'h7FFF_FFFF);
        check("t3_ready", ready_out, 0);

        do_job($urandom);
        wait_start();
        repeat (2) tick();
        do_halt(0);
        idle_done();
        repeat (2) tick();
        check("t4_idle", busy_out, 0);

        do_job(32'h1234_0000);
        wait_start();
        repeat (2) tick();
        do_job(32'h0000_0100);
        check("t5_abort", pool_abort_out, 1);
        check("t5_nonce", nonce_out, 31'h80);
        do_round(2'b01);

        do_job($urandom);
        do_halt(1);
        repeat (3) tick();
        check("halt_job_dropped", busy_out, 0);

        do_job($urandom);
        wait_start();
`ifdef POOL_WATCHDOG_EN
        push(EV_ABORT, cyc + 1 + WD, '0, 0);
        busy_m = 0;
        repeat (WD + 3) tick();
        check("wd_fault", fault_out, 1);
        check("wd_busy", busy_out, 0);
        do_job($urandom);
        check("wd_fault_clear", fault_out, 0);
        do_round(2'b01);
`else
        repeat (WD + 8) tick();
        check("no_wd_fault", fault_out, 0);
        check("no_wd_busy", busy_out, 1);
        do_halt(0);
`endif

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (busy_m) begin
                if (r < 6) begin
                    s = ($urandom_range(0, 2) == 0) ? PS'($urandom_range(1, 3)) : '0;
                    do_round(s);
                end else if (r < 8) do_job(rand_nonce());
                else if (r < 9) do_halt($urandom_range(0, 1));
                else do_reset();
            end else begin
                if (r < 6) do_job(rand_nonce());
                else if (r < 8) idle_done();
                else if (r < 9) do_halt($urandom_range(0, 1));
                else do_reset();
            end
        end

        if (busy_m) do_halt(0);
        repeat (5) tick();
        check("scoreboard_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500_000;
        failures++;
        $display("FAIL global_timeout: got no completion expected finish before 500us");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
